// File: rtl/ram_sync_param_if.sv
// Request/response bundle for ram_sync_param: the master issues enable/write/read
// with address and data, and the slave answers with held read data plus status strobes.
interface ram_sync_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              e;
  logic              w;
  logic              r;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] out;
  logic              valid;
  logic              busy;
  logic              err;

  modport master (output e, w, r, addr, d, input out, valid, busy, err);
  modport slave  (input e, w, r, addr, d, output out, valid, busy, err);
endinterface

// File: rtl/ram_sync_param.sv
// Single-port synchronous RAM with registered read, VALID/ERR strobes, selectable
// read/write collision behaviour and an automatic zero-fill sequence after reset.
module ram_sync_param #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 12,
  parameter int DEPTH          = 1 << ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit WRITE_FIRST    = 1'b0
) (
  input logic             clk,
  input logic             rst,
  ram_sync_param_if.slave bus
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] out_p1;
  logic              vld_p1;
  logic              err_p1;

  logic              acc;
  logic              in_rng;
  logic              wr_en;
  logic              rd_en;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] wdat;

  assign idx = bus.addr[IDX_W-1:0];

  always_comb begin
    acc    = (state == READY) && bus.e && (bus.w || bus.r);
    in_rng = ({1'b0, bus.addr} < DEPTH_L);
    wr_en  = acc && bus.w && in_rng;
    rd_en  = acc && bus.r && in_rng;
    // The clear sequencer borrows the single write port while BUSY.
    mem_we = !rst && ((state == CLEAR) || wr_en);
    widx   = (state == CLEAR) ? cnt : idx;
    wdat   = (state == CLEAR) ? '0 : bus.d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[widx] <= wdat;
  end

  // Stage p1: registered read data with its VALID/ERR strobes, plus the clear FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt    <= '0;
      out_p1 <= '0;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      err_p1 <= acc && !in_rng;
      if (rd_en) out_p1 <= (WRITE_FIRST && bus.w) ? bus.d : mem[idx];
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= READY;
        end
        default: state <= READY;
      endcase
    end
  end

  assign bus.out   = out_p1;
  assign bus.valid = vld_p1;
  assign bus.err   = err_p1;
  assign bus.busy  = (state == CLEAR);

endmodule
